// File: rtl/cvita_uart_arbiter.sv
// Shares one cvita_uart between NUM_PORTS CHDR control requesters: packet-atomic
// round-robin on the request path, owner-routed and packet-locked response path.
module cvita_uart_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [64*NUM_PORTS-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]    s_tlast,
  input  logic [NUM_PORTS-1:0]    s_tvalid,
  output logic [NUM_PORTS-1:0]    s_tready,
  output logic [63:0]             m_tdata,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  input  logic [63:0]             r_tdata,
  input  logic                    r_tlast,
  input  logic                    r_tvalid,
  output logic                    r_tready,
  output logic [64*NUM_PORTS-1:0] d_tdata,
  output logic [NUM_PORTS-1:0]    d_tlast,
  output logic [NUM_PORTS-1:0]    d_tvalid,
  input  logic [NUM_PORTS-1:0]    d_tready,
  output logic [NUM_PORTS-1:0]    grant,
  output logic                    busy
);

  localparam int IW = $clog2(NUM_PORTS);

  // state   | meaning
  // S_IDLE  | no owner; scanning for the next valid requester
  // S_BUSY  | gsel owns the UART input until its tlast beat is accepted
  typedef enum logic {S_IDLE, S_BUSY} req_state_t;

  req_state_t    req_state_q, req_state_d;
  logic [IW-1:0] gsel_q, gsel_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] last_owner_q, last_owner_d;
  logic [IW-1:0] rsel_q, rsel_d;
  logic          r_mid_q, r_mid_d;

  logic [IW-1:0] scan_sel;
  logic          scan_hit;
  logic [IW-1:0] re;
  int            idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_state_q  <= S_IDLE;
      gsel_q       <= '0;
      last_grant_q <= IW'(NUM_PORTS - 1);
      last_owner_q <= '0;
      rsel_q       <= '0;
      r_mid_q      <= 1'b0;
    end else begin
      req_state_q  <= req_state_d;
      gsel_q       <= gsel_d;
      last_grant_q <= last_grant_d;
      last_owner_q <= last_owner_d;
      rsel_q       <= rsel_d;
      r_mid_q      <= r_mid_d;
    end
  end

  // Round-robin scan starting just after the last grant; wrap is explicit so
  // non-power-of-two port counts never index past NUM_PORTS-1.
  always_comb begin
    scan_hit = 1'b0;
    scan_sel = '0;
    idx      = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!scan_hit && s_tvalid[idx]) begin
        scan_hit = 1'b1;
        scan_sel = IW'(idx);
      end
    end
  end

  always_comb begin
    req_state_d  = req_state_q;
    gsel_d       = gsel_q;
    last_grant_d = last_grant_q;
    last_owner_d = last_owner_q;
    m_tdata      = '0;
    m_tlast      = 1'b0;
    m_tvalid     = 1'b0;
    s_tready     = '0;
    grant        = '0;
    busy         = 1'b0;
    case (req_state_q)
      S_IDLE: begin
        if (scan_hit) begin
          gsel_d      = scan_sel;
          req_state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        m_tdata          = s_tdata[64*gsel_q +: 64];
        m_tlast          = s_tlast[gsel_q];
        m_tvalid         = s_tvalid[gsel_q];
        s_tready[gsel_q] = m_tready;
        grant[gsel_q]    = 1'b1;
        busy             = 1'b1;
        if (m_tvalid && m_tready && m_tlast) begin
          req_state_d  = S_IDLE;
          last_grant_d = gsel_q;
          last_owner_d = gsel_q;
        end
      end
      default: req_state_d = S_IDLE;
    endcase
  end

  // Response destination is latched on the first beat so a packet never
  // changes port even if a request completes underneath it.
  assign re       = r_mid_q ? rsel_q : last_owner_q;
  assign d_tdata  = {NUM_PORTS{r_tdata}};
  assign d_tlast  = {NUM_PORTS{r_tlast}};

  always_comb begin
    d_tvalid     = '0;
    d_tvalid[re] = r_tvalid & ~rst;
    r_tready     = d_tready[re] & ~rst;
    r_mid_d      = r_mid_q;
    rsel_d       = rsel_q;
    if (r_tvalid && r_tready) begin
      if (r_tlast) begin
        r_mid_d = 1'b0;
      end else begin
        r_mid_d = 1'b1;
        rsel_d  = re;
      end
    end
  end

endmodule
